// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared FSM encoding, abort read value, client ids and counter sizing.
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;
  localparam logic [15:0] ABORT_RDATA = 16'hDEAD;
  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sdram_arb_timer.sv
// sdram_arb_timer: clearable saturating up-counter with terminal count at LIMIT.
module sdram_arb_timer
  import sdram_arb_pkg::*;
#(
  parameter int LIMIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = cnt_w(LIMIT);
  logic [W-1:0] count;
  assign tc = count == W'(LIMIT);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (en && !tc) count <= count + 1'b1;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: serialises two clients onto the SDRAM controller ports with
// fixed c0 priority, bounded c1 starvation and an abort on a missing controller ack.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_ack,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_ack,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_waddr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_wack,
  output logic              m_rd,
  output logic [ADDR_W-1:0] m_raddr,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rack,
  output logic              busy,
  output logic              timeout_err
);
  state_t state;
  logic op_we, op_client;
  logic starve_tc, to_tc;
  logic pick1, grant, hit, done;
  logic sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_val;
  assign pick1     = c1_req && (!c0_req || starve_tc);
  assign grant     = state == IDLE && (c0_req || c1_req);
  assign sel_we    = pick1 ? c1_we : c0_we;
  assign sel_addr  = pick1 ? c1_addr : c0_addr;
  assign sel_wdata = pick1 ? c1_wdata : c0_wdata;
  assign hit       = op_we ? m_wack : m_rack;
  // A real ack in the same cycle as the terminal count still completes normally.
  assign done      = state == WAIT && (hit || to_tc);
  assign rd_val    = hit ? m_rdata : DATA_W'(ABORT_RDATA);
  assign busy      = state != IDLE;
  // Terminal count one early so the abort lands on the TIMEOUT-th WAIT cycle.
  sdram_arb_timer #(.LIMIT(TIMEOUT - 1)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(state != WAIT),
    .en (state == WAIT),
    .tc (to_tc)
  );
  sdram_arb_timer #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk),
    .rst(rst),
    .clr(grant && (pick1 || !c1_req)),
    .en (grant && !pick1 && c1_req),
    .tc (starve_tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      op_we       <= 1'b0;
      op_client   <= CLIENT0;
      m_wr        <= 1'b0;
      m_rd        <= 1'b0;
      m_waddr     <= '0;
      m_raddr     <= '0;
      m_wdata     <= '0;
      c0_rdata    <= '0;
      c1_rdata    <= '0;
      c0_ack      <= 1'b0;
      c1_ack      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      c0_ack <= 1'b0;
      c1_ack <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          op_we     <= sel_we;
          op_client <= pick1 ? CLIENT1 : CLIENT0;
          m_wr      <= sel_we;
          m_rd      <= !sel_we;
          if (sel_we) begin
            m_waddr <= sel_addr;
            m_wdata <= sel_wdata;
          end else m_raddr <= sel_addr;
          state <= WAIT;
        end
        WAIT: if (done) begin
          m_wr   <= 1'b0;
          m_rd   <= 1'b0;
          c0_ack <= op_client == CLIENT0;
          c1_ack <= op_client == CLIENT1;
          if (!op_we && op_client == CLIENT0) c0_rdata <= rd_val;
          if (!op_we && op_client == CLIENT1) c1_rdata <= rd_val;
          timeout_err <= timeout_err | !hit;
          state <= RELEASE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed self-checking bench for sdram_port_arbiter.
module tb_sdram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c0_req = 0, c0_we = 0, c1_req = 0, c1_we = 0;
  logic [31:0] c0_addr = 0, c1_addr = 0;
  logic [15:0] c0_wdata = 0, c1_wdata = 0;
  logic [15:0] c0_rdata, c1_rdata;
  logic c0_ack, c1_ack;
  logic m_wr, m_rd, busy, timeout_err;
  logic [31:0] m_waddr, m_raddr;
  logic [15:0] m_wdata;
  logic m_wack = 0, m_rack = 0;
  logic [15:0] m_rdata = 0;
  int checks = 0;
  int errors = 0;
  logic exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .c0_ack(c0_ack),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(c1_rdata), .c1_ack(c1_ack),
    .m_wr(m_wr), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wack(m_wack),
    .m_rd(m_rd), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rack(m_rack),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #12;
    chk("reset_outs", {c0_ack, c1_ack, m_wr, m_rd, busy, timeout_err}, 0);
    chk("reset_data", {c0_rdata, c1_rdata}, 0);
    chk("reset_addr", m_waddr | m_raddr | {16'h0, m_wdata}, 0);
    rst = 1'b0;
    tick();
    // c0 read, controller acks on the third WAIT sample
    c0_req = 1; c0_we = 0; c0_addr = 32'h100;
    tick();
    chk("rd_grant", {m_rd, m_wr, busy}, 3'b101);
    chk("rd_addr", m_raddr, 32'h100);
    tick();
    chk("rd_hold1", {m_rd, c0_ack}, 2'b10);
    tick();
    chk("rd_hold2", {m_rd, c0_ack}, 2'b10);
    m_rack = 1; m_rdata = 16'h1234;
    tick();
    chk("rd_done", {m_rd, c0_ack, c1_ack, busy}, 4'b0101);
    chk("rd_data", c0_rdata, 16'h1234);
    m_rack = 0; c0_req = 0; m_rdata = 16'h0;
    tick();
    chk("rd_release", {c0_ack, busy}, 2'b00);
    chk("rd_hold_data", c0_rdata, 16'h1234);
    // stray write ack in IDLE must be ignored
    m_wack = 1;
    tick();
    chk("idle_wack", {busy, c0_ack, c1_ack, m_wr, m_rd}, 0);
    m_wack = 0;
    // c1 write with a spurious read ack
    c1_req = 1; c1_we = 1; c1_addr = 32'h2000; c1_wdata = 16'hBEEF;
    tick();
    chk("wr_grant", {m_wr, m_rd, busy}, 3'b101);
    chk("wr_addr", m_waddr, 32'h2000);
    chk("wr_data", m_wdata, 16'hBEEF);
    c1_addr = 32'hFFFF; c1_wdata = 16'h0;
    m_rack = 1;
    tick();
    chk("wr_spur_rack", {m_wr, m_rd, c1_ack}, 3'b100);
    chk("wr_latched", {m_waddr, m_wdata}, {32'h2000, 16'hBEEF});
    m_rack = 0; m_wack = 1;
    tick();
    chk("wr_done", {m_wr, m_rd, c1_ack, c0_ack}, 4'b0010);
    chk("wr_no_rdata", c1_rdata, 16'h0);
    m_wack = 0; c1_req = 0;
    tick();
    chk("wr_release", {c1_ack, busy}, 2'b00);
    // both clients streaming reads; c1 wins every fifth grant
    c0_req = 1; c0_we = 0; c0_addr = 32'h10;
    c1_req = 1; c1_we = 0; c1_addr = 32'h20;
    m_rack = 1; m_rdata = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("arb_addr%0d", i), m_raddr, exp_order[i] ? 32'h20 : 32'h10);
      tick();
      chk($sformatf("arb_ack%0d", i), {c0_ack, c1_ack}, exp_order[i] ? 2'b01 : 2'b10);
      tick();
    end
    c0_req = 0; c1_req = 0; m_rack = 0;
    chk("arb_idle", busy, 1'b0);
    // c0 read never acked: abort after 1023 WAIT cycles
    c0_addr = 32'h300; c0_req = 1;
    tick();
    chk("to_grant", m_rd, 1'b1);
    for (int i = 1; i < 1023; i++) tick();
    chk("to_pending", {m_rd, c0_ack, timeout_err}, 3'b100);
    tick();
    chk("to_abort", {m_rd, c0_ack, timeout_err}, 3'b011);
    chk("to_rdata", c0_rdata, 16'hDEAD);
    c0_req = 0;
    tick();
    tick();
    chk("to_sticky", {timeout_err, busy, c0_ack}, 3'b100);
    // reset while a write is in WAIT
    c0_req = 1; c0_we = 1; c0_addr = 32'h400; c0_wdata = 16'h7777;
    tick();
    chk("rst_pre", {m_wr, busy}, 2'b11);
    #2 rst = 1;
    #1;
    chk("rst_async", {m_wr, m_rd, busy, timeout_err}, 0);
    c0_req = 0;
    tick();
    chk("rst_no_ack", {c0_ack, c1_ack}, 0);
    rst = 0;
    c1_req = 1; c1_we = 0; c1_addr = 32'h500;
    tick();
    chk("post_rst_grant", {m_rd, m_raddr}, {1'b1, 32'h500});
    m_rack = 1; m_rdata = 16'hCAFE;
    tick();
    chk("post_rst_ack", {c1_ack, c0_ack, m_rd}, 3'b100);
    chk("post_rst_data", c1_rdata, 16'hCAFE);
    m_rack = 0; c1_req = 0;
    tick();
    chk("post_rst_idle", {busy, c1_ack}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
